// File: rtl/rv_instr_encoder_loader.sv
// rv_instr_encoder_loader: packs decoded RV32I fields into 32-bit instruction
// words and writes them to consecutive instruction-memory byte addresses.
// Optional macro ENCODER_RANGE_CHECK_EN: reject requests whose immediate does
// not fit the chosen format (otherwise immediates are silently truncated).
module rv_instr_encoder_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              busy,
  output logic              err_flag,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_done;
  logic              r_err_flag;
  logic [CNT_W-1:0]  r_word_count;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_accept;
  logic              w_fmt_ok;
  logic              w_range_ok;
  logic              w_reject;
  logic              w_start_idle;
  logic [31:0]       w_enc;

  assign in_ready     = (r_state == S_LOAD);
  assign w_accept     = in_valid & in_ready;
  assign w_start_idle = start & (r_state == S_IDLE);
  assign w_reject     = ~w_fmt_ok | ~w_range_ok;

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign done       = r_done;
  assign busy       = (r_state == S_LOAD);
  assign err_flag   = r_err_flag;
  assign word_count = r_word_count;
  assign err_count  = r_err_count;

  // Pack the request fields into the RV32I word for the selected format.
  always_comb begin
    w_enc    = '0;
    w_fmt_ok = 1'b1;
    case (in_fmt)
      FMT_R: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: w_enc = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
      default: w_fmt_ok = 1'b0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Immediate must be a sign extension of the bits the format can hold;
  // branch/jump offsets must also be even.
  always_comb begin
    w_range_ok = 1'b1;
    case (in_fmt)
      FMT_I, FMT_S: w_range_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      FMT_B:        w_range_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1))
                                 && !in_imm[0];
      FMT_J:        w_range_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1))
                                 && !in_imm[0];
      FMT_U:        w_range_ok = (in_imm[11:0] == '0);
      default:      w_range_ok = 1'b1;
    endcase
  end
`else
  // Without range checking every immediate is accepted and truncated.
  always_comb begin
    w_range_ok = 1'b1;
  end
`endif

  // Control FSM: IDLE -> LOAD on start, LOAD -> DONE on last accept, DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_LOAD;
        S_LOAD:  if (w_accept && in_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write port and address pointer; rejected requests leave the pointer alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_idle) begin
        r_addr <= {start_addr[ADDR_W-1:2], 2'b00};
      end else if (w_accept && !w_reject) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_addr;
        r_mem_wdata <= w_enc;
        r_addr      <= r_addr + ADDR_W'(4);
      end
    end
  end

  // End-of-program pulse, reported alongside the final write or rejection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept & in_last;
    end
  end

  // Saturating word/error counters and sticky error flag, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err_flag   <= 1'b0;
    end else if (w_start_idle) begin
      r_word_count <= '0;
      r_err_count  <= '0;
      r_err_flag   <= 1'b0;
    end else if (w_accept) begin
      if (w_reject) begin
        r_err_flag <= 1'b1;
        if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
      end else begin
        if (r_word_count != '1) r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

endmodule
